// File: rtl/knn_local_sp_port_arbiter.sv
// Round-robin arbiter sharing one single-port URAM between a write and a read requester.
// Read data returns through a credit-protected first-word-fall-through response FIFO.
module knn_local_sp_port_arbiter #(
  parameter int DataWidth    = 256,
  parameter int AddressWidth = 11,
  parameter int ReadLatency  = 2,
  parameter int RespDepth    = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [AddressWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0]    wr_data_i,
  input  logic                    rd_valid_i,
  output logic                    rd_ready_o,
  input  logic [AddressWidth-1:0] rd_addr_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DataWidth-1:0]    rsp_data_o,
  output logic [AddressWidth-1:0] mem_address0_o,
  output logic                    mem_ce0_o,
  output logic                    mem_we0_o,
  output logic [DataWidth-1:0]    mem_d0_o,
  input  logic [DataWidth-1:0]    mem_q0_i,
  output logic                    busy_o
);

  localparam int CntW = $clog2(RespDepth + 1);
  localparam int PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;

  typedef enum logic {
    SIDE_WR = 1'b0,
    SIDE_RD = 1'b1
  } side_e;

  side_e                 rr_last_q, rr_last_d;
  logic [ReadLatency-1:0] pipe_q, pipe_d;
  logic [DataWidth-1:0]  fifo_q [RespDepth];
  logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       inflight;
  logic                  rd_ok, wr_gnt, rd_gnt, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(RespDepth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  // Credits cover every read between issue and pop, so the FIFO can never overflow.
  always_comb begin
    inflight = CntW'($countones(pipe_q));
    rd_ok    = rd_valid_i &&
               (({1'b0, inflight} + {1'b0, count_q}) < (CntW + 1)'(RespDepth));
  end

  always_comb begin
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    rr_last_d = rr_last_q;
    if (!reset_i) begin
      if (wr_valid_i && rd_ok) begin
        if (rr_last_q == SIDE_RD) begin
          wr_gnt    = 1'b1;
          rr_last_d = SIDE_WR;
        end else begin
          rd_gnt    = 1'b1;
          rr_last_d = SIDE_RD;
        end
      end else if (wr_valid_i) begin
        wr_gnt = 1'b1;
      end else if (rd_ok) begin
        rd_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ready_o     = wr_gnt;
    rd_ready_o     = rd_gnt;
    mem_ce0_o      = wr_gnt || rd_gnt;
    mem_we0_o      = wr_gnt;
    mem_address0_o = '0;
    mem_d0_o       = '0;
    if (wr_gnt) begin
      mem_address0_o = wr_addr_i;
      mem_d0_o       = wr_data_i;
    end else if (rd_gnt) begin
      mem_address0_o = rd_addr_i;
    end
  end

  always_comb begin
    push        = pipe_q[ReadLatency-1];
    rsp_valid_o = (count_q != '0);
    rsp_data_o  = fifo_q[rptr_q];
    pop         = rsp_valid_o && rsp_ready_i;
    busy_o      = (inflight != '0) || rsp_valid_o;
    pipe_d      = (pipe_q << 1) | ReadLatency'(rd_gnt);
    wptr_d      = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d      = pop ? ptr_inc(rptr_q) : rptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_last_q <= SIDE_RD;
      pipe_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      pipe_q    <= pipe_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push) fifo_q[wptr_q] <= mem_q0_i;
  end

endmodule

// File: tb/tb_knn_local_sp_port_arbiter.sv
// Randomised bench for knn_local_sp_port_arbiter with a URAM model, a
// transaction-level reference model and a response scoreboard.
module tb_knn_local_sp_port_arbiter;
  localparam int DW = 256;
  localparam int AW = 11;
  localparam int RL = 2;
  localparam int RD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i, wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, mem_address0;
  logic [DW-1:0] wr_data, rsp_data, mem_d0, mem_q0;
  logic          rsp_valid, rsp_ready, mem_ce0, mem_we0, busy;

  knn_local_sp_port_arbiter #(
    .DataWidth(DW), .AddressWidth(AW), .ReadLatency(RL), .RespDepth(RD)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .mem_address0_o(mem_address0), .mem_ce0_o(mem_ce0), .mem_we0_o(mem_we0),
    .mem_d0_o(mem_d0), .mem_q0_i(mem_q0), .busy_o(busy)
  );

  // URAM: writes land at the edge, reads emerge RL cycles after issue.
  logic [DW-1:0] ram [2048];
  logic [DW-1:0] rstage [RL];
  always @(posedge clk) begin
    if (mem_ce0 && mem_we0) ram[mem_address0] <= mem_d0;
    rstage[0] <= (mem_ce0 && !mem_we0) ? ram[mem_address0] : '0;
    for (int i = 1; i < RL; i++) rstage[i] <= rstage[i-1];
  end
  assign mem_q0 = rstage[RL-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Reference model: ref_mem is the memory as seen through accepted writes,
  // due_q holds the cycle each outstanding read becomes visible at the FIFO head.
  logic [DW-1:0] ref_mem [2048];
  int            due_q[$];
  logic [DW-1:0] sb[$];
  bit            rr_rd;
  bit            wr_acc, rd_acc;
  int            act_wr_cnt = 0, act_rd_cnt = 0;
  byte           glog[$];

  always @(negedge clk) begin
    bit ok, ewg, erg, erv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    cyc++;
    if (reset_i) begin
      chk("rst_wr_ready", wr_ready, '0);
      chk("rst_rd_ready", rd_ready, '0);
      chk("rst_mem_ce0", mem_ce0, '0);
      due_q.delete();
      sb.delete();
      rr_rd  = 1'b1;
      wr_acc = 1'b0;
      rd_acc = 1'b0;
    end else begin
      ok  = rd_valid && (due_q.size() < RD);
      ewg = 1'b0;
      erg = 1'b0;
      if (wr_valid && ok) begin
        if (rr_rd) ewg = 1'b1; else erg = 1'b1;
        rr_rd = erg;
      end else if (wr_valid) ewg = 1'b1;
      else if (ok) erg = 1'b1;
      ea = ewg ? wr_addr : (erg ? rd_addr : '0);
      ed = ewg ? wr_data : '0;
      erv = (due_q.size() > 0) && (due_q[0] <= cyc);
      chk("wr_ready", wr_ready, ewg);
      chk("rd_ready", rd_ready, erg);
      chk("mem_ce0", mem_ce0, ewg | erg);
      chk("mem_we0", mem_we0, ewg);
      chk("mem_address0", mem_address0, ea);
      chk("mem_d0", mem_d0, ed);
      chk("rsp_valid", rsp_valid, erv);
      chk("busy", busy, due_q.size() > 0);
      if (erv && rsp_ready) void'(due_q.pop_front());
      if (ewg) ref_mem[wr_addr] = wr_data;
      if (erg) begin
        due_q.push_back(cyc + RL + 1);
        sb.push_back(ref_mem[rd_addr]);
      end
      wr_acc = wr_ready && wr_valid;
      rd_acc = rd_ready && rd_valid;
      if (wr_ready) begin act_wr_cnt++; glog.push_back("W"); end
      if (rd_ready) begin act_rd_cnt++; glog.push_back("R"); end
    end
  end

  // Response monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!reset_i && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%0h required=none cycle=%0d", rsp_data, cyc);
      end else begin
        chk("rsp_data", rsp_data, sb.pop_front());
      end
    end
  end

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wreq_t;
  wreq_t         wq[$];
  logic [AW-1:0] rq[$];
  int            rsp_mode;   // 0 stall, 1 ready, 2 random
  bit            rnd_idle;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (wr_acc) begin void'(wq.pop_front()); wr_valid = 1'b0; wr_acc = 1'b0; end
    if (rd_acc) begin void'(rq.pop_front()); rd_valid = 1'b0; rd_acc = 1'b0; end
    if (!wr_valid && wq.size() > 0 && (!rnd_idle || $urandom_range(0, 3) != 0)) wr_valid = 1'b1;
    if (!rd_valid && rq.size() > 0 && (!rnd_idle || $urandom_range(0, 3) != 0)) rd_valid = 1'b1;
    if (wr_valid) begin wr_addr = wq[0].a; wr_data = wq[0].d; end
    if (rd_valid) rd_addr = rq[0];
    rsp_ready = (rsp_mode == 1) || (rsp_mode == 2 && $urandom_range(0, 2) != 0);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((wq.size() > 0 || rq.size() > 0 || wr_valid || rd_valid || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d pending required=0", nm, sb.size() + wq.size() + rq.size());
    end
  endtask

  task automatic do_reset(input int n);
    reset_i = 1'b1;
    repeat (n) step();
    reset_i = 1'b0;
  endtask

  initial begin
    int base, idx;
    reset_i = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    rsp_mode = 1; rnd_idle = 1'b0;
    do_reset(3);
    step();
    chk("reset_rsp_valid", rsp_valid, '0);
    chk("reset_busy", busy, '0);

    // write-only burst
    base = act_wr_cnt;
    for (int i = 0; i < 4; i++) wq.push_back('{a: AW'(i), d: DW'(8'hA0 + i)});
    wait_idle(50, "wr_burst");
    chk("wr_burst_count", 32'(act_wr_cnt - base), 32'd4);

    // read back addr 2 -> 0xA2 after RL+1 cycles
    rq.push_back(AW'(2));
    wait_idle(50, "readback");

    // contention from reset: W,R,W,R,...
    do_reset(2);
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      wq.push_back('{a: AW'(8 + i), d: rand_word()});
      rq.push_back(AW'(i));
    end
    wait_idle(80, "contention");
    for (int i = 0; i < 4; i++) begin
      idx = i;
      chk("contention_grant", (glog.size() > idx) ? 8'(glog[idx]) : 8'd0,
          (idx % 2 == 0) ? 8'("W") : 8'("R"));
    end

    // backpressure: credits stop reads at RespDepth
    rsp_mode = 0;
    base = act_rd_cnt;
    for (int i = 0; i < 6; i++) rq.push_back(AW'(i % 4));
    repeat (12) step();
    chk("backpressure_reads", 32'(act_rd_cnt - base), 32'(RD));
    rsp_mode = 1;
    wait_idle(80, "backpressure");
    chk("backpressure_total", 32'(act_rd_cnt - base), 32'd6);

    // reset while two reads are in flight
    rq.push_back(AW'(1));
    rq.push_back(AW'(3));
    idx = 0;
    while ((rq.size() > 0 || rd_valid) && idx < 20) begin step(); idx++; end
    step();
    do_reset(1);
    repeat (10) step();

    // write then read same address in the next cycle
    wq.push_back('{a: AW'(7), d: DW'(8'h55)});
    step();
    rq.push_back(AW'(7));
    wait_idle(50, "raw");

    // randomised traffic over a small address window
    for (int i = 0; i < 16; i++) wq.push_back('{a: AW'(i), d: rand_word()});
    wait_idle(100, "prefill");
    rsp_mode = 2;
    rnd_idle = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (wq.size() < 2 && $urandom_range(0, 2) == 0)
        wq.push_back('{a: AW'($urandom_range(0, 15)), d: rand_word()});
      if (rq.size() < 2 && $urandom_range(0, 1) == 0)
        rq.push_back(AW'($urandom_range(0, 15)));
      step();
    end
    rsp_mode = 1;
    wait_idle(300, "random_drain");
    step();
    chk("final_busy", busy, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
